// File: rtl/generic_bus_arb_pkg.sv
// Shared types and policy constants for the generic bus arbiter and its winner-select helper.
package generic_bus_arb_pkg;

  typedef enum logic {IDLE, GRANTED} arb_state_t;
  typedef enum logic {REQ_I = 1'b0, REQ_D = 1'b1} arb_owner_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/generic_bus_if.sv
// Generic request/response bus: requester drives addr/wdata/ren/wen/byte_en, target returns rdata/busy/error.
interface generic_bus_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   wdata;
  logic [ADDR_W-1:0]   rdata;
  logic                ren;
  logic                wen;
  logic                busy;
  logic                error;
  logic [ADDR_W/8-1:0] byte_en;

  modport generic_bus (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy, error
  );

  modport cpu (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy, error
  );

endinterface

// File: rtl/arb_pick2.sv
// Combinational 2:1 winner select: fixed data priority, or round-robin against the last grant.
module arb_pick2
  import generic_bus_arb_pkg::*;
#(
  parameter int ARB_POLICY = ARB_FIXED
) (
  input  logic       req_i,
  input  logic       req_d,
  input  arb_owner_t last_grant,
  output arb_owner_t winner
);

  always_comb begin
    winner = REQ_I;
    if (req_i && req_d) begin
      winner = (ARB_POLICY == ARB_RR && last_grant == REQ_D) ? REQ_I : REQ_D;
    end else if (req_d) begin
      winner = REQ_D;
    end
  end

endmodule

// File: rtl/generic_bus_arbiter.sv
// Shares one downstream generic bus between icache and dcache requesters, one grant at a time.
// Define GENERIC_BUS_ARBITER_STATS_EN to add grant and contention counters.
module generic_bus_arbiter
  import generic_bus_arb_pkg::*;
#(
  parameter int ARB_POLICY = ARB_FIXED,
  parameter int ADDR_W     = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  generic_bus_if.generic_bus icache_gen_bus_if,
  generic_bus_if.generic_bus dcache_gen_bus_if,
  generic_bus_if.cpu         out_gen_bus_if,
  output logic               grant_owner,
  output logic               active
`ifdef GENERIC_BUS_ARBITER_STATS_EN
  ,
  output logic [31:0]        icache_grants,
  output logic [31:0]        dcache_grants,
  output logic [31:0]        contention_cycles
`endif
);

  localparam int BE_W = ADDR_W / 8;

  arb_state_t state, next_state;
  arb_owner_t owner, next_owner, last_grant, next_last_grant, winner;

  logic              req_i, req_d, done;
  logic [ADDR_W-1:0] dn_addr, dn_wdata;
  logic              dn_ren, dn_wen;
  logic [BE_W-1:0]   dn_be;
  logic              i_busy, d_busy, i_error, d_error;
  logic [ADDR_W-1:0] i_rdata, d_rdata;

  assign req_i = icache_gen_bus_if.ren | icache_gen_bus_if.wen;
  assign req_d = dcache_gen_bus_if.ren | dcache_gen_bus_if.wen;
  assign done  = (state == GRANTED) && !out_gen_bus_if.busy;

  arb_pick2 #(
    .ARB_POLICY(ARB_POLICY)
  ) u_pick (
    .req_i     (req_i),
    .req_d     (req_d),
    .last_grant(last_grant),
    .winner    (winner)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      owner      <= REQ_I;
      last_grant <= REQ_I;
    end else begin
      state      <= next_state;
      owner      <= next_owner;
      last_grant <= next_last_grant;
    end
  end

  // No abort path: a GRANTED transfer only ends when the downstream drops busy.
  always_comb begin
    next_state      = state;
    next_owner      = owner;
    next_last_grant = last_grant;
    unique case (state)
      IDLE: begin
        if (req_i || req_d) begin
          next_state = GRANTED;
          next_owner = winner;
        end
      end
      GRANTED: begin
        if (done) begin
          next_state      = IDLE;
          next_last_grant = owner;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dn_addr  = '0;
    dn_wdata = '0;
    dn_ren   = 1'b0;
    dn_wen   = 1'b0;
    dn_be    = '0;
    if (state == GRANTED) begin
      if (owner == REQ_D) begin
        dn_addr  = dcache_gen_bus_if.addr;
        dn_wdata = dcache_gen_bus_if.wdata;
        dn_ren   = dcache_gen_bus_if.ren;
        dn_wen   = dcache_gen_bus_if.wen;
        dn_be    = dcache_gen_bus_if.byte_en;
      end else begin
        dn_addr  = icache_gen_bus_if.addr;
        dn_wdata = icache_gen_bus_if.wdata;
        dn_ren   = icache_gen_bus_if.ren;
        dn_wen   = icache_gen_bus_if.wen;
        dn_be    = icache_gen_bus_if.byte_en;
      end
    end
  end

  // Response data and error are only released to the owner on the completion cycle.
  always_comb begin
    i_busy  = 1'b1;
    d_busy  = 1'b1;
    i_error = 1'b0;
    d_error = 1'b0;
    i_rdata = '0;
    d_rdata = '0;
    if (done) begin
      if (owner == REQ_D) begin
        d_busy  = 1'b0;
        d_error = out_gen_bus_if.error;
        d_rdata = out_gen_bus_if.rdata;
      end else begin
        i_busy  = 1'b0;
        i_error = out_gen_bus_if.error;
        i_rdata = out_gen_bus_if.rdata;
      end
    end
  end

  assign out_gen_bus_if.addr    = dn_addr;
  assign out_gen_bus_if.wdata   = dn_wdata;
  assign out_gen_bus_if.ren     = dn_ren;
  assign out_gen_bus_if.wen     = dn_wen;
  assign out_gen_bus_if.byte_en = dn_be;

  assign icache_gen_bus_if.busy  = i_busy;
  assign icache_gen_bus_if.error = i_error;
  assign icache_gen_bus_if.rdata = i_rdata;
  assign dcache_gen_bus_if.busy  = d_busy;
  assign dcache_gen_bus_if.error = d_error;
  assign dcache_gen_bus_if.rdata = d_rdata;

  assign active      = (state == GRANTED);
  assign grant_owner = owner;

`ifdef GENERIC_BUS_ARBITER_STATS_EN
  logic contend;

  assign contend = ((state == IDLE) && req_i && req_d) ||
                   ((state == GRANTED) && ((owner == REQ_D) ? req_i : req_d));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icache_grants     <= '0;
      dcache_grants     <= '0;
      contention_cycles <= '0;
    end else begin
      if (done && owner == REQ_I) icache_grants <= icache_grants + 32'd1;
      if (done && owner == REQ_D) dcache_grants <= dcache_grants + 32'd1;
      if (contend) contention_cycles <= contention_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Bench for generic_bus_arbiter: one DUT per policy, directed scenarios plus random traffic vs a transaction model.
module tb_generic_bus_arbiter;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  // Index [p] selects the DUT (= its ARB_POLICY), [r] the requester (0 = icache, 1 = dcache).
  logic [31:0] rq_addr [2][2];
  logic [31:0] rq_wdata[2][2];
  logic        rq_ren  [2][2];
  logic        rq_wen  [2][2];
  logic [3:0]  rq_be   [2][2];
  logic [31:0] rs_rdata[2][2];
  logic        rs_busy [2][2];
  logic        rs_error[2][2];
  logic        ds_busy [2];
  logic        ds_error[2];
  logic [31:0] ds_rdata[2];
  logic [31:0] dn_addr [2];
  logic [31:0] dn_wdata[2];
  logic        dn_ren  [2];
  logic        dn_wen  [2];
  logic [3:0]  dn_be   [2];
  logic        gnt     [2];
  logic        act     [2];
`ifdef GENERIC_BUS_ARBITER_STATS_EN
  logic [31:0] st_ig[2];
  logic [31:0] st_dg[2];
  logic [31:0] st_cc[2];
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  string grant_order;

  for (genvar p = 0; p < 2; p++) begin : g_dut
    generic_bus_if #(.ADDR_W(32)) bi ();
    generic_bus_if #(.ADDR_W(32)) bd ();
    generic_bus_if #(.ADDR_W(32)) bo ();

    assign bi.addr = rq_addr[p][0];  assign bi.wdata = rq_wdata[p][0];
    assign bi.ren  = rq_ren[p][0];   assign bi.wen   = rq_wen[p][0];   assign bi.byte_en = rq_be[p][0];
    assign bd.addr = rq_addr[p][1];  assign bd.wdata = rq_wdata[p][1];
    assign bd.ren  = rq_ren[p][1];   assign bd.wen   = rq_wen[p][1];   assign bd.byte_en = rq_be[p][1];
    assign rs_rdata[p][0] = bi.rdata; assign rs_busy[p][0] = bi.busy; assign rs_error[p][0] = bi.error;
    assign rs_rdata[p][1] = bd.rdata; assign rs_busy[p][1] = bd.busy; assign rs_error[p][1] = bd.error;
    assign bo.busy = ds_busy[p];     assign bo.rdata = ds_rdata[p];    assign bo.error = ds_error[p];
    assign dn_addr[p] = bo.addr;     assign dn_wdata[p] = bo.wdata;    assign dn_be[p] = bo.byte_en;
    assign dn_ren[p]  = bo.ren;      assign dn_wen[p]   = bo.wen;

    generic_bus_arbiter #(
      .ARB_POLICY(p),
      .ADDR_W    (32)
    ) u_dut (
      .CLK              (CLK),
      .nRST             (nRST),
      .icache_gen_bus_if(bi),
      .dcache_gen_bus_if(bd),
      .out_gen_bus_if   (bo),
      .grant_owner      (gnt[p]),
      .active           (act[p])
`ifdef GENERIC_BUS_ARBITER_STATS_EN
      ,
      .icache_grants    (st_ig[p]),
      .dcache_grants    (st_dg[p]),
      .contention_cycles(st_cc[p])
`endif
    );
  end

  task automatic clear_inputs();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 2; r++) begin
        rq_addr[p][r] = '0; rq_wdata[p][r] = '0; rq_ren[p][r] = 1'b0;
        rq_wen[p][r]  = 1'b0; rq_be[p][r] = '0;
      end
      ds_busy[p] = 1'b1; ds_rdata[p] = '0; ds_error[p] = 1'b0;
    end
  endtask

  // Leaves the caller 1 time unit after a rising edge with both DUTs idle.
  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clear_inputs();
    for (int p = 0; p < 2; p++) begin
      rq_ren[p][0] = 1'b1; rq_wen[p][1] = 1'b1; ds_busy[p] = 1'b0; ds_rdata[p] = 32'h1234_5678;
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int p = 0; p < 2; p++) begin
      n_tests++;
      if (act[p] !== 1'b0 || gnt[p] !== 1'b0 || dn_ren[p] !== 1'b0 || dn_wen[p] !== 1'b0 ||
          dn_addr[p] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state p%0d: act=%b gnt=%b ren=%b wen=%b addr=%h, want 0", p, act[p],
                 gnt[p], dn_ren[p], dn_wen[p], dn_addr[p]);
      end
      for (int r = 0; r < 2; r++) begin
        n_tests++;
        if (rs_busy[p][r] !== 1'b1 || rs_rdata[p][r] !== 32'h0 || rs_error[p][r] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_resp p%0d r%0d: busy=%b rdata=%h err=%b, want 1/0/0", p, r,
                   rs_busy[p][r], rs_rdata[p][r], rs_error[p][r]);
        end
      end
    end
    clear_inputs();
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single_read();
    do_reset();
    rq_ren[0][0] = 1'b1; rq_addr[0][0] = 32'h0000_1000; rq_be[0][0] = 4'hF;
    @(negedge CLK);
    n_tests++;
    if (act[0] !== 1'b0 || dn_ren[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_no_speculation: act=%b ren=%b, want 0/0", act[0], dn_ren[0]);
    end
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK); #1;
      ds_busy[0] = (k != 3); ds_rdata[0] = 32'hDEAD_BEEF;
      @(negedge CLK);
      n_tests++;
      if (act[0] !== 1'b1 || gnt[0] !== 1'b0 || dn_ren[0] !== 1'b1 || dn_addr[0] !== 32'h1000) begin
        n_fail++;
        $display("FAIL sr_forward c%0d: act=%b gnt=%b ren=%b addr=%h, want 1/0/1/00001000", k,
                 act[0], gnt[0], dn_ren[0], dn_addr[0]);
      end
      n_tests++;
      if (rs_busy[0][0] !== (k != 3) || rs_busy[0][1] !== 1'b1) begin
        n_fail++;
        $display("FAIL sr_busy c%0d: ibusy=%b dbusy=%b, want %b/1", k, rs_busy[0][0],
                 rs_busy[0][1], (k != 3));
      end
      if (k == 3) begin
        n_tests++;
        if (rs_rdata[0][0] !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL sr_rdata: got %h want deadbeef", rs_rdata[0][0]);
        end
      end
    end
    @(posedge CLK); #1;
    rq_ren[0][0] = 1'b0; ds_busy[0] = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (act[0] !== 1'b0 || rs_busy[0][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sr_release: act=%b ibusy=%b, want 0/1", act[0], rs_busy[0][0]);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_data_error();
    logic [31:0] wd;
    wd = $urandom;
    do_reset();
    rq_wen[0][1] = 1'b1; rq_addr[0][1] = 32'hA5A5_0000; rq_be[0][1] = 4'b0011; rq_wdata[0][1] = wd;
    @(posedge CLK); #1;
    ds_busy[0] = 1'b0; ds_error[0] = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (dn_wen[0] !== 1'b1 || dn_ren[0] !== 1'b0 || dn_addr[0] !== 32'hA5A5_0000 ||
        dn_be[0] !== 4'b0011 || dn_wdata[0] !== wd || gnt[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_forward: wen=%b ren=%b addr=%h be=%b wdata=%h gnt=%b, want 1/0/a5a50000/0011/%h/1",
               dn_wen[0], dn_ren[0], dn_addr[0], dn_be[0], dn_wdata[0], gnt[0], wd);
    end
    n_tests++;
    if (rs_error[0][1] !== 1'b1 || rs_busy[0][1] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_owner: err=%b busy=%b, want 1/0", rs_error[0][1], rs_busy[0][1]);
    end
    n_tests++;
    if (rs_error[0][0] !== 1'b0 || rs_busy[0][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_other: err=%b busy=%b, want 0/1", rs_error[0][0], rs_busy[0][0]);
    end
    @(posedge CLK); #1;
    rq_wen[0][1] = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (rs_error[0][1] !== 1'b0 || act[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_not_held: err=%b act=%b, want 0/0", rs_error[0][1], act[0]);
    end
    ds_error[0] = 1'b0; ds_busy[0] = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rq_ren[0][0] = 1'b1; rq_addr[0][0] = 32'h0000_2000;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_tests++;
    if (act[0] !== 1'b1 || dn_ren[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_granted: act=%b ren=%b, want 1/1", act[0], dn_ren[0]);
    end
    #2 nRST = 1'b0;
    #1;
    n_tests++;
    if (act[0] !== 1'b0 || dn_ren[0] !== 1'b0 || dn_wen[0] !== 1'b0 || rs_busy[0][0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_async: act=%b ren=%b wen=%b ibusy=%b, want 0/0/0/1", act[0], dn_ren[0],
               dn_wen[0], rs_busy[0][0]);
    end
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_tests++;
    if (act[0] !== 1'b1 || gnt[0] !== 1'b0 || dn_ren[0] !== 1'b1 || dn_addr[0] !== 32'h2000) begin
      n_fail++;
      $display("FAIL rm_regrant: act=%b gnt=%b ren=%b addr=%h, want 1/0/1/00002000", act[0],
               gnt[0], dn_ren[0], dn_addr[0]);
    end
    @(posedge CLK); #1;
    ds_busy[0] = 1'b0;
    @(posedge CLK); #1;
    rq_ren[0][0] = 1'b0; ds_busy[0] = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Transaction-level model: the bus is free or owned; a grant starts the cycle after requests are
  // seen while free, lasts a bench-chosen number of cycles, and is followed by one free cycle.
  task automatic run_traffic(input int p, input int max_cyc, input int quota_i, input int quota_d,
                             input bit rnd);
    bit pend[2];
    int left[2], exp_cnt[2];
    int own, done_at, last, exp_cont, o;
    bit comp;
    pend = '{1'b0, 1'b0}; left[0] = quota_i; left[1] = quota_d; exp_cnt = '{0, 0};
    own = -1; done_at = 0; last = 0; exp_cont = 0; grant_order = "";
    do_reset();
    for (int c = 0; c < max_cyc; c++) begin
      if (!rnd && own < 0 && left[0] == 0 && left[1] == 0) break;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && (rnd ? ($urandom_range(0, 2) == 0) : (left[r] > 0))) begin
          pend[r] = 1'b1; o = $urandom_range(0, 1);
          rq_addr[p][r] = $urandom; rq_wdata[p][r] = $urandom; rq_be[p][r] = 4'($urandom);
          rq_ren[p][r] = (o == 0); rq_wen[p][r] = (o == 1);
        end
        if (!pend[r]) begin rq_ren[p][r] = 1'b0; rq_wen[p][r] = 1'b0; end
      end
      comp = (own >= 0) && (c == done_at);
      ds_busy[p] = (own >= 0) ? !comp : 1'($urandom);
      ds_rdata[p] = $urandom; ds_error[p] = 1'($urandom);
      if ((own < 0 && pend[0] && pend[1]) || (own >= 0 && pend[1 - own])) exp_cont++;
      @(negedge CLK);
      if (own < 0) begin
        n_tests++;
        if (act[p] !== 1'b0 || dn_ren[p] !== 1'b0 || dn_wen[p] !== 1'b0 || dn_addr[p] !== 32'h0 ||
            dn_wdata[p] !== 32'h0 || dn_be[p] !== 4'h0) begin
          n_fail++;
          $display("FAIL idle_down p%0d c%0d: act=%b ren=%b wen=%b addr=%h wdata=%h be=%h, want all 0",
                   p, c, act[p], dn_ren[p], dn_wen[p], dn_addr[p], dn_wdata[p], dn_be[p]);
        end
        for (int r = 0; r < 2; r++) begin
          n_tests++;
          if (rs_busy[p][r] !== 1'b1 || rs_rdata[p][r] !== 32'h0 || rs_error[p][r] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_resp p%0d c%0d r%0d: busy=%b rdata=%h err=%b, want 1/0/0", p, c, r,
                     rs_busy[p][r], rs_rdata[p][r], rs_error[p][r]);
          end
        end
      end else begin
        n_tests++;
        if (act[p] !== 1'b1 || gnt[p] !== (own == 1)) begin
          n_fail++;
          $display("FAIL grant p%0d c%0d: act=%b gnt=%b, want 1/%0d", p, c, act[p], gnt[p], own);
        end
        n_tests++;
        if (dn_addr[p] !== rq_addr[p][own] || dn_wdata[p] !== rq_wdata[p][own] ||
            dn_ren[p] !== rq_ren[p][own] || dn_wen[p] !== rq_wen[p][own] ||
            dn_be[p] !== rq_be[p][own]) begin
          n_fail++;
          $display("FAIL forward p%0d c%0d: addr=%h ren=%b wen=%b, want %h/%b/%b", p, c, dn_addr[p],
                   dn_ren[p], dn_wen[p], rq_addr[p][own], rq_ren[p][own], rq_wen[p][own]);
        end
        n_tests++;
        if (rs_busy[p][own] !== !comp || rs_rdata[p][own] !== (comp ? ds_rdata[p] : 32'h0) ||
            rs_error[p][own] !== (comp ? ds_error[p] : 1'b0)) begin
          n_fail++;
          $display("FAIL owner_resp p%0d c%0d: busy=%b rdata=%h err=%b, want %b/%h/%b", p, c,
                   rs_busy[p][own], rs_rdata[p][own], rs_error[p][own], !comp,
                   (comp ? ds_rdata[p] : 32'h0), (comp ? ds_error[p] : 1'b0));
        end
        n_tests++;
        if (rs_busy[p][1-own] !== 1'b1 || rs_rdata[p][1-own] !== 32'h0 ||
            rs_error[p][1-own] !== 1'b0) begin
          n_fail++;
          $display("FAIL other_resp p%0d c%0d: busy=%b rdata=%h err=%b, want 1/0/0", p, c,
                   rs_busy[p][1-own], rs_rdata[p][1-own], rs_error[p][1-own]);
        end
      end
      @(posedge CLK); #1;
      if (own < 0) begin
        if (pend[0] || pend[1]) begin
          if (pend[0] && pend[1]) own = (p == 1 && last == 1) ? 0 : 1;
          else own = pend[1] ? 1 : 0;
          done_at = c + (rnd ? int'($urandom_range(1, 3)) : 1 + int'($urandom_range(0, 1)));
          grant_order = {grant_order, (own == 1) ? "D" : "I"};
        end
      end else if (comp) begin
        pend[own] = 1'b0; left[own]--; exp_cnt[own]++; last = own; own = -1;
      end
    end
    if (!rnd) begin
      n_tests++;
      if (own >= 0 || left[0] != 0 || left[1] != 0) begin
        n_fail++;
        $display("FAIL quota_timeout p%0d: left_i=%0d left_d=%0d, want 0/0", p, left[0], left[1]);
      end
    end
`ifdef GENERIC_BUS_ARBITER_STATS_EN
    n_tests++;
    if (st_ig[p] !== 32'(exp_cnt[0]) || st_dg[p] !== 32'(exp_cnt[1]) ||
        st_cc[p] !== 32'(exp_cont)) begin
      n_fail++;
      $display("FAIL stats p%0d: i=%0d d=%0d cont=%0d, want %0d/%0d/%0d", p, st_ig[p], st_dg[p],
               st_cc[p], exp_cnt[0], exp_cnt[1], exp_cont);
    end
`endif
    clear_inputs();
  endtask

  task automatic test_fixed_contention();
    run_traffic(0, 200, 2, 3, 1'b0);
    n_tests++;
    if (grant_order != "DDDII") begin
      n_fail++;
      $display("FAIL fixed_order: got %s want DDDII", grant_order);
    end
`ifdef GENERIC_BUS_ARBITER_STATS_EN
    n_tests++;
    if (st_cc[0] == 32'h0) begin
      n_fail++;
      $display("FAIL fixed_contention: got %0d want >0", st_cc[0]);
    end
`endif
  endtask

  task automatic test_rr_alternate();
    run_traffic(1, 200, 3, 3, 1'b0);
    n_tests++;
    if (grant_order != "DIDIDI") begin
      n_fail++;
      $display("FAIL rr_order: got %s want DIDIDI", grant_order);
    end
  endtask

  task automatic test_random();
    run_traffic(0, 400, 0, 0, 1'b1);
    run_traffic(1, 400, 0, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_data_error();
    test_reset_mid();
    test_fixed_contention();
    test_rr_alternate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
